// File: rtl/pattern_hflipper.sv
// pattern_hflipper: horizontal mirror for one pattern line in the sprite path.
// Pixel k of a line sits at bits [W-1-k*BPP -: BPP], so pixel 0 is the leftmost pixel
// and occupies the MSBs. With hflip=1 the pixel order is reversed. The bit order
// inside each pixel is kept as it is.
// Build option PATTERN_HFLIP_COMB_EN: when defined, the output path is purely
// combinational with zero latency, and clk/rst are ignored. When undefined (the
// default), the result is registered with a latency of one cycle.
module pattern_hflipper #(
  parameter int PIXELS = 8,
  parameter int BPP    = 2,
  parameter int W      = PIXELS * BPP,
  parameter int SEL_W  = $clog2(PIXELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     pattern_in,
  input  logic             hflip,
  input  logic [SEL_W-1:0] px_sel,
  output logic             out_valid,
  output logic [W-1:0]     pattern_out,
  output logic [BPP-1:0]   pixel_out
);

  // Reverse the order of the BPP-wide pixel chunks and leave each chunk's bits alone.
  // This is a pure permutation of the input bits.
  function automatic logic [W-1:0] flip_line(input logic [W-1:0] line,
                                             input logic         do_flip);
    logic [W-1:0] res;
    res = line;
    if (do_flip) begin
      for (int k = 0; k < PIXELS; k++) begin
        res[(PIXELS-1-k)*BPP +: BPP] = line[k*BPP +: BPP];
      end
    end else begin
      res = line;
    end
    return res;
  endfunction

  logic [W-1:0] flipped_s;

  // Mirror (or pass through) the incoming line.
  always_comb begin
    flipped_s = flip_line(pattern_in, hflip);
  end

`ifdef PATTERN_HFLIP_COMB_EN

  // clk and rst are not used in this build. Folding them into a signal named
  // "unused" keeps the ports in place without leaving them dangling.
  logic unused_s;

  // Gather the ignored clock and reset into one sink signal.
  always_comb begin
    unused_s = &{1'b0, clk, rst};
  end

  // Zero-latency path: the outputs follow the inputs directly.
  always_comb begin
    out_valid   = in_valid;
    pattern_out = flipped_s;
  end

`else

  logic         valid_d;
  logic         valid_q;
  logic [W-1:0] pattern_d;
  logic [W-1:0] pattern_q;

  // Next state: take a new line only when the input is valid, otherwise hold the old one.
  always_comb begin
    valid_d = in_valid;
    if (in_valid) begin
      pattern_d = flipped_s;
    end else begin
      pattern_d = pattern_q;
    end
  end

  // Output registers. An asynchronous reset drops any line that is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      pattern_q <= {W{1'b0}};
    end else begin
      valid_q   <= valid_d;
      pattern_q <= pattern_d;
    end
  end

  // Drive the outputs straight from the flops.
  always_comb begin
    out_valid   = valid_q;
    pattern_out = pattern_q;
  end

`endif

  logic [BPP-1:0] pixel_s;

  // Per-pixel tap: select pixel px_sel of pattern_out. Pixel 0 is the MSB chunk.
  always_comb begin
    pixel_s = {BPP{1'b0}};
    for (int k = 0; k < PIXELS; k++) begin
      if (px_sel == k[SEL_W-1:0]) begin
        pixel_s = pattern_out[(PIXELS-1-k)*BPP +: BPP];
      end else begin
        pixel_s = pixel_s;
      end
    end
  end

  // Drive the pixel tap output.
  always_comb begin
    pixel_out = pixel_s;
  end

endmodule

// File: tb/tb_pattern_hflipper.sv
// Directed testbench for pattern_hflipper (PIXELS=8, BPP=2).
// The expected values are worked out by hand from the mirror definition.
module tb_pattern_hflipper;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] pattern_in;
  logic        hflip;
  logic [2:0]  px_sel;
  logic        out_valid;
  logic [15:0] pattern_out;
  logic [1:0]  pixel_out;

  int chk_cnt;
  int pass_cnt;

  pattern_hflipper dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .pattern_in  (pattern_in),
    .hflip       (hflip),
    .px_sel      (px_sel),
    .out_valid   (out_valid),
    .pattern_out (pattern_out),
    .pixel_out   (pixel_out)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Wait until the applied input is visible at the outputs.
  task automatic settle();
`ifdef PATTERN_HFLIP_COMB_EN
    #1;
`else
    @(posedge clk);
    #1;
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst        = 1'b0;
    in_valid   = 1'b1;
    pattern_in = 16'hFFFF;
    hflip      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (pattern_out !== 16'h0000) $display("FAIL reset_pattern: got %h want 0000", pattern_out);
    else pass_cnt++;
    chk_cnt++;
    if (pixel_out !== 2'b00) $display("FAIL reset_pixel: got %b want 00", pixel_out);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL idle_valid: got %b want 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (pattern_out !== 16'h0000) $display("FAIL idle_pattern: got %h want 0000", pattern_out);
    else pass_cnt++;
  endtask

  task automatic test_flip();
    @(negedge clk);
    in_valid   = 1'b1;
    pattern_in = 16'b00_01_10_11_00_01_10_11;
    hflip      = 1'b1;
    px_sel     = 3'd0;
    settle();
    chk_cnt++;
    if (pattern_out !== 16'b11_10_01_00_11_10_01_00)
      $display("FAIL flip_pattern: got %b want 1110010011100100", pattern_out);
    else pass_cnt++;
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL flip_valid: got %b want 1", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (pixel_out !== 2'b11) $display("FAIL flip_pixel0: got %b want 11", pixel_out);
    else pass_cnt++;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    in_valid   = 1'b1;
    pattern_in = 16'b00_01_10_11_00_01_10_11;
    hflip      = 1'b0;
    px_sel     = 3'd2;
    settle();
    chk_cnt++;
    if (pattern_out !== 16'b00_01_10_11_00_01_10_11)
      $display("FAIL pass_pattern: got %b want 0001101100011011", pattern_out);
    else pass_cnt++;
    chk_cnt++;
    if (pixel_out !== 2'b10) $display("FAIL pass_pixel2: got %b want 10", pixel_out);
    else pass_cnt++;
  endtask

  task automatic test_pixel_order();
    @(negedge clk);
    in_valid   = 1'b1;
    pattern_in = 16'h4000;
    hflip      = 1'b1;
    px_sel     = 3'd7;
    settle();
    chk_cnt++;
    if (pattern_out !== 16'h0001) $display("FAIL order_pattern: got %h want 0001", pattern_out);
    else pass_cnt++;
    chk_cnt++;
    if (pixel_out !== 2'b01) $display("FAIL order_pixel7: got %b want 01", pixel_out);
    else pass_cnt++;
    px_sel = 3'd0;
    #1;
    chk_cnt++;
    if (pixel_out !== 2'b00) $display("FAIL order_pixel0: got %b want 00", pixel_out);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid   = 1'b1;
    pattern_in = 16'hC000;
    hflip      = 1'b1;
    settle();
    chk_cnt++;
    if (pattern_out !== 16'h0003) $display("FAIL b2b_first: got %h want 0003", pattern_out);
    else pass_cnt++;
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL b2b_first_valid: got %b want 1", out_valid);
    else pass_cnt++;
    @(negedge clk);
    hflip = 1'b0;
    settle();
    chk_cnt++;
    if (pattern_out !== 16'hC000) $display("FAIL b2b_second: got %h want c000", pattern_out);
    else pass_cnt++;
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL b2b_second_valid: got %b want 1", out_valid);
    else pass_cnt++;
`ifndef PATTERN_HFLIP_COMB_EN
    @(negedge clk);
    in_valid   = 1'b0;
    pattern_in = 16'h1234;
    hflip      = 1'b1;
    settle();
    chk_cnt++;
    if (pattern_out !== 16'hC000) $display("FAIL b2b_hold: got %h want c000", pattern_out);
    else pass_cnt++;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL b2b_hold_valid: got %b want 0", out_valid);
    else pass_cnt++;
`endif
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in_valid   = 1'b1;
    pattern_in = 16'h5A5A;
    hflip      = 1'b0;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL arst_pre_valid: got %b want 1", out_valid);
    else pass_cnt++;
    #1;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (pattern_out !== 16'h0000) $display("FAIL arst_pattern: got %h want 0000", pattern_out);
    else pass_cnt++;
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
  endtask

  // Run the scenarios in order, then print the summary.
  initial begin
    chk_cnt    = 0;
    pass_cnt   = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    pattern_in = 16'h0000;
    hflip      = 1'b0;
    px_sel     = 3'd0;
`ifdef PATTERN_HFLIP_COMB_EN
    rst = 1'b1;
`else
    test_reset();
`endif
    test_flip();
    test_passthrough();
    test_pixel_order();
    test_back_to_back();
`ifndef PATTERN_HFLIP_COMB_EN
    test_async_reset();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
